// File: rtl/idct_1d.sv
// idct_1d: 8-point one-dimensional inverse DCT.
// Collects X[0]..X[7] (one per enabled cycle). A completed block is handed to
// a compute stage that evaluates one output sample per cycle as a full 8-tap
// dot product against a cosine table scaled by 2^15. x[n] is driven
// 9 cycles after the cycle in which X[7] is accepted.
// The optional macro IDCT_SAT_FLAG_EN adds the sat_out port. That port flags
// samples that were clamped to the OUT_W range.
module idct_1d #(
  parameter int IN_W  = 12,
  parameter int OUT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena_in,
  input  logic                    sync_in,
  input  logic signed [IN_W-1:0]  coeff_in,
  output logic signed [OUT_W-1:0] sample_out,
  output logic                    valid_out,
  output logic                    first_out
`ifdef IDCT_SAT_FLAG_EN
  ,
  output logic                    sat_out
`endif
);

  // CW: cosine table word width. FRAC: table scale, 2^15.
  localparam int CW   = 16;
  localparam int FRAC = 15;
  // PW: product width. SW: width of the 8-term sum; cannot overflow.
  localparam int PW   = IN_W + CW;
  localparam int SW   = PW + 3;
  // DLY: delay stages that align the result with the fixed output latency.
  localparam int DLY  = 4;

  localparam logic signed [SW-1:0] P_HALF = SW'(1 << (FRAC - 1));
  localparam logic signed [SW-1:0] P_MAX  = SW'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] P_MIN  = ~P_MAX;

  // Table entry j gives cos(j*pi/16)/2 scaled by 2^15. Only j = 1..7 are needed.
  function automatic logic signed [CW-1:0] half_cos(input int j);
    case (j)
      1:       half_cos = 16'sd16069;
      2:       half_cos = 16'sd15137;
      3:       half_cos = 16'sd13623;
      4:       half_cos = 16'sd11585;
      5:       half_cos = 16'sd9102;
      6:       half_cos = 16'sd6270;
      7:       half_cos = 16'sd3196;
      default: half_cos = 16'sd0;
    endcase
  endfunction

  // Returns the basis weight (C(k)/2)*cos((2n+1)k*pi/16).
  // The angle is folded into the first quadrant and the sign is applied.
  // For k = 0 the weight is 1/(2*sqrt2), which is the same value as cos(4*pi/16)/2.
  function automatic logic signed [CW-1:0] coef(input logic [2:0] n, input int k);
    int m;
    m = ((2 * int'(n) + 1) * k) % 32;
    if (k == 0) return half_cos(4);
    if (m > 16) m = 32 - m;
    if (m > 8) return -half_cos(16 - m);
    return half_cos(m);
  endfunction

  // ---------------- input collection ----------------
  logic [2:0]             r_k;
  logic signed [IN_W-1:0] r_in  [0:6];
  logic signed [IN_W-1:0] r_blk [0:7];
  logic                   w_done;

  // The block completes on a normal accept at k=7.
  // A sync accept at k=7 does not complete it, because that accept starts a new block instead.
  assign w_done = ena_in & ~sync_in & (r_k == 3'd7);

  // Input index: advances on each accept. A sync accept stores X[0], so the index restarts at 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  r_k <= '0;
    else if (ena_in && sync_in)  r_k <= 3'd1;
    else if (ena_in)             r_k <= r_k + 3'd1;
  end

  // Partial-block buffer for X[0]..X[6].
  // X[7] is not stored here; it goes straight into the compute buffer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 7; i++) r_in[i] <= '0;
    end else begin
      for (int i = 0; i < 7; i++)
        if (ena_in && (sync_in ? (i == 0) : (r_k == 3'(i))))
          r_in[i] <= coeff_in;
    end
  end

  // ---------------- compute buffer and sample sequencer ----------------
  logic       r_busy;
  logic [2:0] r_n;

  // Ping-pong handover.
  // A finished block is copied into the compute buffer, and samples n = 0..7 are then issued.
  // The next block cannot finish until the last sample has been issued, so there is no overlap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy <= 1'b0;
      r_n    <= '0;
      for (int i = 0; i < 8; i++) r_blk[i] <= '0;
    end else if (w_done) begin
      for (int i = 0; i < 7; i++) r_blk[i] <= r_in[i];
      r_blk[7] <= coeff_in;
      r_busy   <= 1'b1;
      r_n      <= '0;
    end else if (r_busy) begin
      r_n <= r_n + 3'd1;
      if (r_n == 3'd7) r_busy <= 1'b0;
    end
  end

  // ---------------- datapath ----------------
  logic signed [CW-1:0] w_coef [0:7];
  logic signed [PW-1:0] w_prod [0:7];

  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_tap
      assign w_coef[gi] = coef(r_n, gi);
      assign w_prod[gi] = $signed({{IN_W{w_coef[gi][CW-1]}}, w_coef[gi]}) *
                          $signed({{CW{r_blk[gi][IN_W-1]}}, r_blk[gi]});
    end
  endgenerate

  logic signed [PW-1:0] r_prod [0:7];
  logic signed [PW:0]   r_s4   [0:3];
  logic signed [PW+1:0] r_s2   [0:1];
  logic signed [SW-1:0] r_s1;
  logic [3:0]           r_vp;
  logic [3:0]           r_fp;

  // Products, then a three-level adder tree.
  // The valid and first markers travel alongside in a shift register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_prod[i] <= '0;
      for (int i = 0; i < 4; i++) r_s4[i] <= '0;
      for (int i = 0; i < 2; i++) r_s2[i] <= '0;
      r_s1 <= '0;
      r_vp <= '0;
      r_fp <= '0;
    end else begin
      for (int i = 0; i < 8; i++) r_prod[i] <= w_prod[i];
      for (int i = 0; i < 4; i++)
        r_s4[i] <= {r_prod[2*i][PW-1], r_prod[2*i]} + {r_prod[2*i+1][PW-1], r_prod[2*i+1]};
      for (int i = 0; i < 2; i++)
        r_s2[i] <= {r_s4[2*i][PW], r_s4[2*i]} + {r_s4[2*i+1][PW], r_s4[2*i+1]};
      r_s1 <= {r_s2[0][PW+1], r_s2[0]} + {r_s2[1][PW+1], r_s2[1]};
      r_vp <= {r_vp[2:0], r_busy};
      r_fp <= {r_fp[2:0], r_busy & (r_n == 3'd0)};
    end
  end

  logic signed [SW-1:0]    w_sum_r;
  logic signed [SW-1:0]    w_rnd;
  logic signed [OUT_W-1:0] w_smp;
`ifdef IDCT_SAT_FLAG_EN
  logic                    w_sat;
`endif

  // Rounding adds half an LSB and then shifts right arithmetically (round half up).
  assign w_sum_r = r_s1 + P_HALF;
  assign w_rnd   = w_sum_r >>> FRAC;

  // Saturate the rounded value to the signed OUT_W range.
  always_comb begin
    w_smp = w_rnd[OUT_W-1:0];
`ifdef IDCT_SAT_FLAG_EN
    w_sat = 1'b0;
`endif
    if (w_rnd > P_MAX) begin
      w_smp = P_MAX[OUT_W-1:0];
`ifdef IDCT_SAT_FLAG_EN
      w_sat = 1'b1;
`endif
    end else if (w_rnd < P_MIN) begin
      w_smp = P_MIN[OUT_W-1:0];
`ifdef IDCT_SAT_FLAG_EN
      w_sat = 1'b1;
`endif
    end
  end

  // ---------------- output alignment ----------------
  logic signed [OUT_W-1:0] r_dx [0:DLY-1];
  logic [DLY-1:0]          r_dv;
  logic [DLY-1:0]          r_df;
`ifdef IDCT_SAT_FLAG_EN
  logic [DLY-1:0]          r_ds;
`endif

  // Delay line that sets the fixed latency. Its last stage drives the ports directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DLY; i++) r_dx[i] <= '0;
      r_dv <= '0;
      r_df <= '0;
`ifdef IDCT_SAT_FLAG_EN
      r_ds <= '0;
`endif
    end else begin
      r_dx[0] <= w_smp;
      for (int i = 1; i < DLY; i++) r_dx[i] <= r_dx[i-1];
      r_dv <= {r_dv[DLY-2:0], r_vp[3]};
      r_df <= {r_df[DLY-2:0], r_fp[3]};
`ifdef IDCT_SAT_FLAG_EN
      r_ds <= {r_ds[DLY-2:0], w_sat & r_vp[3]};
`endif
    end
  end

  assign sample_out = r_dx[DLY-1];
  assign valid_out  = r_dv[DLY-1];
  assign first_out  = r_df[DLY-1];
`ifdef IDCT_SAT_FLAG_EN
  assign sat_out    = r_ds[DLY-1];
`endif

endmodule

// File: tb/tb_idct_1d.sv
// Testbench for idct_1d.
// Stimulus mixes directed blocks with random blocks.
// A floating-point IDCT reference predicts every output cycle.
module tb_idct_1d;
  localparam int  IN_W  = 12;
  localparam int  OUT_W = 8;
  localparam int  NS    = 64;
  localparam real PI    = 3.14159265358979;
  localparam int  OMAX  = (1 << (OUT_W - 1)) - 1;
  localparam int  OMIN  = -(1 << (OUT_W - 1));

  logic                    clk      = 1'b0;
  logic                    rst_n    = 1'b0;
  logic                    ena_in   = 1'b0;
  logic                    sync_in  = 1'b0;
  logic signed [IN_W-1:0]  coeff_in = '0;
  logic signed [OUT_W-1:0] sample_out;
  logic                    valid_out;
  logic                    first_out;
`ifdef IDCT_SAT_FLAG_EN
  logic                    sat_out;
`endif

  idct_1d #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena_in     (ena_in),
    .sync_in    (sync_in),
    .coeff_in   (coeff_in),
    .sample_out (sample_out),
    .valid_out  (valid_out),
    .first_out  (first_out)
`ifdef IDCT_SAT_FLAG_EN
    ,
    .sat_out    (sat_out)
`endif
  );

  always #5 clk = ~clk;

  int  n_vec = 0;
  int  n_err = 0;
  int  nc    = 0;
  int  mk    = 0;
  int  mblk  [8];
  int  exp_v [NS];
  int  exp_f [NS];
  int  exp_x [NS];
  int  exp_s [NS];
  int  exp_a [NS];

  task automatic check(input string tag, input int got, input int want, input int tol);
    n_vec++;
    if (got > want + tol || got < want - tol) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d (tol %0d)", tag, nc, got, want, tol);
    end
  endtask

  // Real-valued orthonormal IDCT of the current model block.
  function automatic real ref_val(input int n);
    real acc;
    real ck;
    acc = 0.0;
    for (int k = 0; k < 8; k++) begin
      ck  = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
      acc = acc + ck / 2.0 * real'(mblk[k]) * $cos(real'((2 * n + 1) * k) * PI / 16.0);
    end
    return acc;
  endfunction

  // Round half away from zero.
  function automatic int round_haz(input real v);
    if (v >= 0.0) return int'($floor(v + 0.5));
    return -int'($floor(-v + 0.5));
  endfunction

  // Record the expected outputs of a completed block.
  // X[7] is accepted at the edge numbered nc+1, so x[n] appears after edge nc+9+n.
  task automatic schedule();
    int  s;
    int  r;
    real v;
    int  xs [8];
    for (int n = 0; n < 8; n++) begin
      s        = (nc + 9 + n) % NS;
      v        = ref_val(n);
      r        = round_haz(v);
      exp_v[s] = 1;
      exp_f[s] = (n == 0) ? 1 : 0;
      exp_s[s] = (r > OMAX || r < OMIN) ? 1 : 0;
      exp_x[s] = (r > OMAX) ? OMAX : ((r < OMIN) ? OMIN : r);
      exp_a[s] = ((v > 127.0 && v < 128.0) || (v > -129.0 && v < -128.0)) ? 1 : 0;
      xs[n]    = exp_x[s];
    end
    $display("block @cyc %0d X=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d -> x=%0d,%0d,%0d,%0d,%0d,%0d,%0d,%0d",
             nc + 1, mblk[0], mblk[1], mblk[2], mblk[3], mblk[4], mblk[5], mblk[6], mblk[7],
             xs[0], xs[1], xs[2], xs[3], xs[4], xs[5], xs[6], xs[7]);
  endtask

  // Monitor and model.
  // At each falling edge, outputs from the last rising edge are checked first.
  // Then the inputs that the next rising edge will accept are applied to the model.
  initial begin : monitor
    int slot;
    forever begin
      @(negedge clk or negedge rst_n);
      if (clk && !rst_n) begin
        #1;
        check("rst_valid", int'(valid_out), 0, 0);
        check("rst_sample", int'(sample_out), 0, 0);
        check("rst_first", int'(first_out), 0, 0);
      end else if (!clk) begin
        nc++;
        slot = nc % NS;
        if (!rst_n) begin
          check("rst_hold_valid", int'(valid_out), 0, 0);
          check("rst_hold_sample", int'(sample_out), 0, 0);
          for (int i = 0; i < NS; i++) exp_v[i] = 0;
          mk = 0;
        end else begin
          check("valid", int'(valid_out), exp_v[slot], 0);
          if (exp_v[slot] != 0) begin
            check("first", int'(first_out), exp_f[slot], 0);
            check("sample", int'(sample_out), exp_x[slot], 1);
`ifdef IDCT_SAT_FLAG_EN
            if (exp_a[slot] == 0) check("sat", int'(sat_out), exp_s[slot], 0);
`endif
          end else begin
            check("first_idle", int'(first_out), 0, 0);
`ifdef IDCT_SAT_FLAG_EN
            check("sat_idle", int'(sat_out), 0, 0);
`endif
          end
          exp_v[slot] = 0;
          if (ena_in) begin
            if (sync_in) begin
              mblk[0] = int'(coeff_in);
              mk      = 1;
            end else begin
              mblk[mk] = int'(coeff_in);
              if (mk == 7) schedule();
              mk = (mk + 1) % 8;
            end
          end
        end
      end
    end
  end

  task automatic drive(input bit e, input bit s, input int v);
    @(posedge clk);
    #1;
    ena_in   = e;
    sync_in  = s;
    coeff_in = IN_W'(v);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, int'($urandom_range(0, 255)));
  endtask

  // Send one block. The first coefficient can carry sync_in.
  // An optional run of idle cycles can follow coefficient gap_at.
  task automatic send_block(input int b [8], input bit first_sync, input int gap_at, input int gap_len);
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, (i == 0) ? first_sync : 1'b0, b[i]);
      if (i == gap_at) idle(gap_len);
    end
  endtask

  function automatic int rnd_coef();
    if ($urandom_range(0, 3) == 0) return int'($urandom_range(0, 4095)) - 2048;
    return int'($urandom_range(0, 600)) - 300;
  endfunction

  initial begin : stim
    int b  [8];
    int b2 [8];
    int np;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);

    // Directed blocks sent back to back: DC, both saturation directions, single AC, all zero.
    b = '{64, 0, 0, 0, 0, 0, 0, 0};     send_block(b, 1'b0, -1, 0);
    b = '{1000, 0, 0, 0, 0, 0, 0, 0};   send_block(b, 1'b0, -1, 0);
    b = '{-1000, 0, 0, 0, 0, 0, 0, 0};  send_block(b, 1'b0, -1, 0);
    b = '{0, 100, 0, 0, 0, 0, 0, 0};    send_block(b, 1'b0, -1, 0);
    b = '{0, 0, 0, 0, 0, 0, 0, 0};      send_block(b, 1'b0, -1, 0);
    idle(20);

    // ena_in dropped for 5 cycles after X[3].
    b = '{0, 100, 0, 0, 0, 0, 0, 0};    send_block(b, 1'b0, 3, 5);
    idle(20);

    // sync_in arrives together with what would have been X[5]. The old partial block is dropped.
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 500 + i);
    b = '{64, -40, 30, 0, 12, 0, -7, 3}; send_block(b, 1'b1, -1, 0);
    idle(20);

    // Random blocks with random gaps and occasional resyncs.
    for (int t = 0; t < 40; t++) begin
      for (int i = 0; i < 8; i++) b[i] = rnd_coef();
      if ($urandom_range(0, 5) == 0) begin
        np = int'($urandom_range(1, 7));
        for (int i = 0; i < np; i++) drive(1'b1, 1'b0, rnd_coef());
        send_block(b, 1'b1, int'($urandom_range(0, 7)), int'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 1) == 0) begin
        send_block(b, 1'b0, -1, 0);
      end else begin
        send_block(b, ($urandom_range(0, 3) == 0), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 4)));
      end
    end
    idle(20);

    // Reset while x[3] is on the output.
    b  = '{0, 100, 0, 0, 0, 0, 0, 0};
    send_block(b, 1'b0, -1, 0);
    drive(1'b0, 1'b0, 0);
    repeat (11) @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(30);
    for (int i = 0; i < 8; i++) b2[i] = rnd_coef();
    send_block(b2, 1'b0, -1, 0);
    idle(25);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
